uart_rx_fifo: RTL and testbench

//  UART receive front end (8N1) with RTS flow control and a show-ahead byte FIFO.

---
 rtl/uart_rx_fifo_if.sv | 11 +
 rtl/uart_rx_fifo.sv | 112 +++++++++++
 tb/tb_uart_rx_fifo.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: show-ahead read port of the receive FIFO; the FIFO side is the slave.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  logic [7:0] rd_data;
  logic rd_valid;
  logic rd_pop;
  logic [$clog2(DEPTH):0] fifo_count;
  modport master (input rd_data, rd_valid, fifo_count, output rd_pop);
  modport slave (output rd_data, rd_valid, fifo_count, input rd_pop);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with RTS flow control feeding a show-ahead byte FIFO.
// Optional UART_RX_MAJORITY_EN: data/stop bits use a 3-sample majority vote.
module uart_rx_fifo #(
  parameter int CLK_HZ = 8000000,
  parameter int BAUD = 125000,
  parameter int DEPTH = 16,
  parameter int RTS_MARGIN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rts,
  output logic frame_err,
  output logic overrun,
  input  logic err_clr,
  uart_rx_fifo_if.slave rd
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW = $clog2(CPB);
  localparam int AW = $clog2(DEPTH);
  localparam int KW = AW + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic rx_m, rx_s, bit_v, at_bit, push, bad_stop, push_ok, pop_ok;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [KW-1:0] count, count_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rx_m, rx_s} <= 2'b11;
    else {rx_m, rx_s} <= {rx, rx_m};
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hist <= 2'b11;
    else hist <= {hist[0], rx_s};
  assign bit_v = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_v = rx_s;
`endif
  assign at_bit = cnt == CW'(CPB - 1);
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    push = 1'b0;
    bad_stop = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : START;
      end
      START: if (cnt == CW'(CPB / 2 - 1)) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (at_bit) begin
        cnt_n = '0;
        sh_n = {bit_v, sh[7:1]};
        idx_n = idx + 1'b1;
        state_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (at_bit) begin
        state_n = IDLE;
        push = bit_v;
        bad_stop = !bit_v;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
    end
  // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
  assign pop_ok = rd.rd_pop && count != '0;
  assign push_ok = push && (count < KW'(DEPTH) || rd.rd_pop);
  assign count_n = count + KW'(push_ok) - KW'(pop_ok);
  always_ff @(posedge clk)
    if (push_ok) mem[wptr] <= sh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      rts <= 1'b1;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      wptr <= wptr + AW'(push_ok);
      rptr <= rptr + AW'(pop_ok);
      count <= count_n;
      rts <= count_n >= KW'(DEPTH - RTS_MARGIN);
      frame_err <= err_clr ? 1'b0 : frame_err | bad_stop;
      overrun <= err_clr ? 1'b0 : overrun | (push & !push_ok);
    end
  assign rd.rd_valid = count != '0;
  assign rd.rd_data = rd.rd_valid ? mem[rptr] : 8'h00;
  assign rd.fifo_count = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: vector table, directed corner sequences and random frames against a queue model.
`timescale 1ns/100ps
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic err_clr = 1'b0;
  logic rts, frame_err, overrun;
  uart_rx_fifo_if #(.DEPTH(16)) rd_if ();
  uart_rx_fifo dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rts(rts), .frame_err(frame_err),
    .overrun(overrun), .err_clr(err_clr), .rd(rd_if)
  );
  always #62.5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int q[$];
  logic m_ferr = 1'b0;
  logic m_ovr = 1'b0;
  typedef struct {logic [7:0] d; logic stop; int cnt; logic ferr;} vec_t;
  vec_t tbl [5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_frame(input logic [7:0] d, input logic stop);
    if (!stop) m_ferr = 1'b1;
    else if (q.size() < 16) q.push_back(d);
    else m_ovr = 1'b1;
  endtask
  task automatic check_state(input string name);
    chk({name, " count"}, rd_if.fifo_count, q.size());
    chk({name, " rts"}, rts, q.size() >= 12);
    chk({name, " frame_err"}, frame_err, m_ferr);
    chk({name, " overrun"}, overrun, m_ovr);
    chk({name, " valid"}, rd_if.rd_valid, q.size() != 0);
    if (q.size() != 0) chk({name, " head"}, rd_if.rd_data, q[0]);
  endtask
  // One 8N1 frame of 64 clk per bit; optional pop pulse and 1-clk rx inversion at given clk offsets.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int pop_at = -1,
                            input int glitch_at = -1);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int k = 0; k < 640; k++) begin
      @(negedge clk);
      rx = f[k / 64] ^ (k == glitch_at);
      rd_if.rd_pop = (k == pop_at);
    end
    @(negedge clk);
    rx = 1'b1;
    rd_if.rd_pop = 1'b0;
  endtask
  task automatic pop();
    @(negedge clk);
    rd_if.rd_pop = 1'b1;
    @(negedge clk);
    rd_if.rd_pop = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask
  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
  endtask
  initial begin
    logic [9:0] f;
    logic [7:0] g_exp;
    rd_if.rd_pop = 1'b0;
    tbl[0] = '{8'hDE, 1'b1, 1, 1'b0};
    tbl[1] = '{8'hAD, 1'b1, 2, 1'b0};
    tbl[2] = '{8'hBE, 1'b1, 3, 1'b0};
    tbl[3] = '{8'hEF, 1'b1, 4, 1'b0};
    tbl[4] = '{8'h55, 1'b0, 4, 1'b1};
    repeat (3) @(negedge clk);
    chk("reset rts", rts, 1);
    chk("reset count", rd_if.fifo_count, 0);
    chk("reset valid", rd_if.rd_valid, 0);
    chk("reset data", rd_if.rd_data, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overrun", overrun, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rts after release", rts, 0);
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].d, tbl[i].stop);
      model_frame(tbl[i].d, tbl[i].stop);
      chk("t1 count", rd_if.fifo_count, tbl[i].cnt);
      chk("t1 frame_err", frame_err, tbl[i].ferr);
    end
    for (int i = 0; i < 4; i++) begin
      chk("t1 pop data", rd_if.rd_data, tbl[i].d);
      pop();
    end
    chk("t1 empty", rd_if.fifo_count, 0);
    clear_err();
    check_state("t1 cleared");
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("t2 count", rd_if.fifo_count, 0);
    chk("t2 frame_err", frame_err, 0);
    send_frame(8'h55, 1'b0);
    model_frame(8'h55, 1'b0);
    chk("t3 frame_err", frame_err, 1);
    chk("t3 count", rd_if.fifo_count, 0);
    clear_err();
    chk("t3 cleared", frame_err, 0);
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1);
      model_frame(8'(i), 1'b1);
      chk("t4 rts", rts, i + 1 >= 12);
      check_state("t4");
    end
    chk("t4 full", rd_if.fifo_count, 16);
    chk("t4 overrun", overrun, 1);
    for (int i = 0; i < 16; i++) begin
      chk("t4 pop data", rd_if.rd_data, i);
      pop();
    end
    clear_err();
    for (int i = 0; i < 16; i++) begin
      send_frame(8'h20 + 8'(i), 1'b1);
      model_frame(8'h20 + 8'(i), 1'b1);
    end
    // Push lands on the stop-bit sample at clk 610 of the frame; pop there too.
    send_frame(8'h30, 1'b1, 610);
    void'(q.pop_front());
    model_frame(8'h30, 1'b1);
    chk("t5 count", rd_if.fifo_count, 16);
    chk("t5 overrun", overrun, 0);
    check_state("t5");
    for (int i = 0; i < 16; i++) begin
      chk("t5 drain", rd_if.rd_data, q[0]);
      pop();
    end
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    model_frame(8'h11, 1'b1);
    model_frame(8'h22, 1'b1);
    check_state("t6 queued");
    f = {1'b1, 8'h5A, 1'b0};
    for (int k = 0; k < 288; k++) begin
      @(negedge clk);
      rx = f[k / 64];
    end
    @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    chk("t6 reset count", rd_if.fifo_count, 0);
    chk("t6 reset rts", rts, 1);
    chk("t6 reset valid", rd_if.rd_valid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    @(negedge clk);
    chk("t6 rts release", rts, 0);
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1);
    chk("t6 rx after reset", rd_if.rd_data, 8'hA5);
    check_state("t6");
    pop();
`ifdef UART_RX_MAJORITY_EN
    g_exp = 8'h00;
`else
    g_exp = 8'h01;
`endif
    send_frame(8'h00, 1'b1, -1, 96);
    model_frame(g_exp, 1'b1);
    chk("t7 glitch", rd_if.rd_data, g_exp);
    pop();
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      logic s;
      d = 8'($urandom);
      s = $urandom_range(0, 7) != 0;
      send_frame(d, s);
      model_frame(d, s);
      check_state("rand frame");
      for (int p = $urandom_range(0, 3); p > 0; p--) pop();
      check_state("rand pop");
      if ($urandom_range(0, 3) == 0) begin
        clear_err();
        check_state("rand clr");
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
